// File: rtl/dds_channel_combiner_if.sv
// rtl/dds_channel_combiner_if.sv - AXI-Stream style composite sample bus
// Ports (via modports):
//   master: drives tdata/tuser/tlast/tvalid, samples tready
//   slave : samples tdata/tuser/tlast/tvalid, drives tready
interface dds_channel_combiner_if #(
    parameter int DW = 16
);
    logic [DW-1:0] tdata;
    logic          tuser;
    logic          tlast;
    logic          tvalid;
    logic          tready;

    modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/dds_channel_combiner.sv
// rtl/dds_channel_combiner.sv - sums NUM_CH interleaved DDS samples, scales, saturates, buffers to AXI-Stream
// Optional feature macro: DDS_CMB_ROUND_EN (round half up before the shift when SHIFT > 0)
// Ports:
//   clk        clock
//   a_rst_n    asynchronous reset, active-low
//   i_clr      synchronous clear, priority over i_valid
//   i_sample   signed channel sample, qualified by i_valid
//   m_axis     AXI-Stream master (tdata composite, tuser saturated, tlast end of frame)
//   o_overflow sticky flag: a composite was dropped on a full FIFO
//   o_drop_cnt saturating count of dropped composites
module dds_channel_combiner #(
    parameter int NUM_CH     = 3,
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_LEN  = 4
) (
    input  logic                       clk,
    input  logic                       a_rst_n,
    input  logic                       i_clr,
    input  logic signed [IN_WIDTH-1:0] i_sample,
    input  logic                       i_valid,
    dds_channel_combiner_if.master     m_axis,
    output logic                       o_overflow,
    output logic [15:0]                o_drop_cnt
);
    localparam int CLOG  = $clog2(NUM_CH);
    localparam int AW    = IN_WIDTH + CLOG + 1;
    localparam int CW    = (NUM_CH > 1) ? CLOG : 1;
    localparam int EW    = (AW > OUT_WIDTH) ? AW : OUT_WIDTH;
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int RND_I = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;

    logic [CW-1:0]           ch_q, ch_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic                    pipe_vld_q, pipe_vld_d;
    logic [OUT_WIDTH-1:0]    pipe_data_q, pipe_data_d;
    logic                    pipe_sat_q, pipe_sat_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]             count_q, count_d;
    logic [FW-1:0]           frame_q, frame_d;
    logic                    ovf_q, ovf_d;
    logic [15:0]             drop_q, drop_d;

    logic [OUT_WIDTH-1:0]    mem_data_q [FIFO_DEPTH];
    logic                    mem_user_q [FIFO_DEPTH];
    logic                    mem_last_q [FIFO_DEPTH];

    logic signed [AW-1:0]    sample_ext, acc_base, sum, sum_rnd, shifted;
    logic signed [EW-1:0]    shifted_ext;
    logic                    fits, sat_flag, last_ch;
    logic [OUT_WIDTH-1:0]    sat_val;
    logic                    full, pop, push, drop, tvalid;

    assign sample_ext = AW'(i_sample);
    // First channel of a group restarts the sum instead of adding to stale acc.
    assign acc_base   = (ch_q == '0) ? '0 : acc_q;
    assign sum        = acc_base + sample_ext;
`ifdef DDS_CMB_ROUND_EN
    assign sum_rnd    = sum + AW'(RND_I);
`else
    assign sum_rnd    = sum;
`endif
    assign shifted     = sum_rnd >>> SHIFT;
    assign shifted_ext = EW'(shifted);
    // Value fits in OUT_WIDTH when all bits above the output sign bit match it.
    assign fits     = (&shifted_ext[EW-1:OUT_WIDTH-1]) | ~(|shifted_ext[EW-1:OUT_WIDTH-1]);
    assign sat_flag = ~fits;
    assign sat_val  = fits ? shifted_ext[OUT_WIDTH-1:0]
                    : (shifted_ext[EW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                         : {1'b0, {(OUT_WIDTH-1){1'b1}}});
    assign last_ch  = (ch_q == CW'(NUM_CH - 1));

    assign tvalid = (count_q != '0);
    assign full   = (count_q == (PW+1)'(FIFO_DEPTH));
    assign pop    = tvalid && m_axis.tready;
    assign push   = pipe_vld_q && (!full || pop);
    assign drop   = pipe_vld_q && full && !pop;

    always_comb begin
        ch_d        = ch_q;
        acc_d       = acc_q;
        pipe_vld_d  = 1'b0;
        pipe_data_d = pipe_data_q;
        pipe_sat_d  = pipe_sat_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + (PW+1)'(push) - (PW+1)'(pop);
        frame_d     = frame_q;
        ovf_d       = ovf_q | drop;
        drop_d      = drop_q;
        if (i_valid) begin
            acc_d = sum;
            ch_d  = last_ch ? '0 : ch_q + CW'(1);
            if (last_ch) begin
                pipe_vld_d  = 1'b1;
                pipe_data_d = sat_val;
                pipe_sat_d  = sat_flag;
            end
        end
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            frame_d  = (frame_q == FW'(FRAME_LEN - 1)) ? '0 : frame_q + FW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        if (drop && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n || i_clr) begin
            ch_q        <= '0;
            acc_q       <= '0;
            pipe_vld_q  <= 1'b0;
            pipe_data_q <= '0;
            pipe_sat_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_q     <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= '0;
        end else begin
            ch_q        <= ch_d;
            acc_q       <= acc_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_data_q <= pipe_data_d;
            pipe_sat_q  <= pipe_sat_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_q     <= frame_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
        end
    end

    // Storage needs no reset: outputs are gated by tvalid below.
    always_ff @(posedge clk) begin
        if (push && !i_clr) begin
            mem_data_q[wr_ptr_q] <= pipe_data_q;
            mem_user_q[wr_ptr_q] <= pipe_sat_q;
            mem_last_q[wr_ptr_q] <= (frame_q == FW'(FRAME_LEN - 1));
        end
    end

    assign m_axis.tvalid = tvalid;
    assign m_axis.tdata  = tvalid ? mem_data_q[rd_ptr_q] : '0;
    assign m_axis.tuser  = tvalid ? mem_user_q[rd_ptr_q] : 1'b0;
    assign m_axis.tlast  = tvalid ? mem_last_q[rd_ptr_q] : 1'b0;
    assign o_overflow    = ovf_q;
    assign o_drop_cnt    = drop_q;
endmodule

// File: doc/dds_channel_combiner.md
Name: dds_channel_combiner

Overview:
Downstream stage of the DDS core. Consumes the time-multiplexed per-channel sample stream (amplitude × sine) and sums every NUM_CH consecutive samples into one composite sample. Scales and saturates the composite, then buffers it in a small FIFO drained over an AXI-Stream master toward the DAC/DMA path. Also provides frame marking (tlast), overflow flags and drop counting.

Parameters:
NUM_CH, 3, channels interleaved per composite sample (>=1)
IN_WIDTH, 16, signed input sample width
OUT_WIDTH, 16, signed composite output width
SHIFT, 0, arithmetic right shift applied to the sum before saturation
FIFO_DEPTH, 4, output FIFO entries (power of 2)
FRAME_LEN, 4, composite samples per AXI-Stream frame (tlast period)

Ports:
clk  input  1  clock
a_rst_n  input  1  asynchronous reset, active-low
i_clr  input  1  synchronous clear (tied to dds_rst)
i_sample  input  IN_WIDTH  signed channel sample from DDS
i_valid  input  1  qualifies i_sample
m_axis_tdata  output  OUT_WIDTH  composite sample
m_axis_tuser  output  1  composite was saturated
m_axis_tlast  output  1  last sample of frame
m_axis_tvalid  output  1  AXI-Stream valid
m_axis_tready  input  1  AXI-Stream ready
o_overflow  output  1  sticky: composite dropped on full FIFO
o_drop_cnt  output  16  dropped composite count, saturates at 0xFFFF

Behaviour:
- Reset (a_rst_n=0, or i_clr=1 at an edge): channel counter=0, accumulator=0, pipeline valid=0, FIFO empty, frame counter=0, o_overflow=0, o_drop_cnt=0, m_axis_tvalid=0, tdata/tuser/tlast=0.
- i_clr has priority over i_valid; the sample in the clearing cycle is discarded.
- Channel counter ch: advances on each accepted sample (i_valid=1); wraps NUM_CH-1 -> 0.
- Accumulator width AW = IN_WIDTH + clog2(NUM_CH) + 1, signed. ch==0: acc <= sext(i_sample). Otherwise acc <= acc + sext(i_sample).
- When ch==NUM_CH-1 and i_valid: sum = acc + i_sample is formed combinationally, arithmetically shifted right by SHIFT, and saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. The result and its sat flag are registered into the pipeline register at that edge (edge k).
- At edge k+1 the pipeline register is pushed into the FIFO. m_axis_tvalid rises after edge k+1 if the FIFO was empty, i.e. 2 cycles of latency from the last channel sample to tvalid.
- Push succeeds if FIFO not full, or if full with a pop in the same cycle (count unchanged).
- Push with FIFO full and no pop: composite dropped, o_overflow <= 1 (sticky until reset/i_clr), o_drop_cnt increments (saturating). The frame counter does not advance.
- The frame counter counts successful pushes, 0..FRAME_LEN-1. The entry pushed at count FRAME_LEN-1 is stored with tlast=1, and the counter wraps.
- AXI-Stream: pop on tvalid && tready. tdata/tuser/tlast are held stable while tvalid && !tready. Order is strictly FIFO.
- i_valid has no backpressure. The DDS stream is never stalled; loss is only through FIFO drop.

Optional Feature:
DDS_CMB_ROUND_EN
- Defined: add 2^(SHIFT-1) to the sum before the shift (round half up). This applies only when SHIFT>0, and the rounding carry is absorbed by the AW guard bit before saturation.
- Undefined: plain truncation (arithmetic shift toward -inf).
- Latency is identical in both cases.

Test Plan:
- Basic sum (NUM_CH=3, SHIFT=0, tready=1): i_valid samples 100,200,300 -> tdata=600, tuser=0, tvalid exactly 2 cycles after the 300 sample.
- Saturation: 20000,20000,0 -> tdata=32767, tuser=1. Then -20000,-20000,-1 -> tdata=-32768, tuser=1.
- Backpressure/overflow (FIFO_DEPTH=4, tready=0): 5 composites 1..5 -> FIFO holds 1..4, o_overflow=1, o_drop_cnt=1. Then tready=1 -> outputs 1,2,3,4 in order, and tvalid falls after 4.
- Framing (FRAME_LEN=4): 8 composites with tready=1 -> tlast=1 only on the 4th and 8th. A dropped composite does not shift the tlast position.
- Clear mid-frame: samples 7,9, then i_clr=1 together with i_valid=1 (sample 50), then 1,2,3 -> single output 6. The 50 sample is ignored, and overflow/drop count are cleared.
- Rounding (SHIFT=1): samples 1,0,0 -> 0 without DDS_CMB_ROUND_EN, 1 with it. Samples -1,0,0 -> -1 without it, 0 with it.
